// File: rtl/door_controller_pkg.sv
// Shared definitions for the door controller: state encodings and sizing helpers.
package door_controller_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } door_state_e;

    // Larger of two unsigned values, used to size the shared timer.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/door_controller_if.sv
// Request/sensor inputs and motor/status outputs of the door controller.
// Optional macro: DOOR_OPEN_CNT_EN adds the completed-openings counter.
interface door_controller_if
    import door_controller_pkg::*;
#(
    parameter int unsigned N_REQ = 2
`ifdef DOOR_OPEN_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
);

    logic               lock_i;
    logic [N_REQ-1:0]   req_i;
    logic [N_REQ-1:0]   req_mask_i;
    logic               open_lim_i;
    logic               closed_lim_i;
    logic               obstacle_i;
    logic               motor_open_o;
    logic               motor_close_o;
    logic               door_open_o;
    logic               fault_o;
    logic [STATE_W-1:0] state_o;
`ifdef DOOR_OPEN_CNT_EN
    logic [CNT_W-1:0]   open_count_o;
`endif

    // Request/sensor side.
    modport master (
        output lock_i, req_i, req_mask_i, open_lim_i, closed_lim_i, obstacle_i,
        input  motor_open_o, motor_close_o, door_open_o, fault_o, state_o
`ifdef DOOR_OPEN_CNT_EN
        , input open_count_o
`endif
    );

    // Controller side.
    modport slave (
        input  lock_i, req_i, req_mask_i, open_lim_i, closed_lim_i, obstacle_i,
        output motor_open_o, motor_close_o, door_open_o, fault_o, state_o
`ifdef DOOR_OPEN_CNT_EN
        , output open_count_o
`endif
    );

endinterface

// File: rtl/door_controller_timer.sv
// Loadable down-counter that stops at zero instead of wrapping.
module door_controller_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero_c
);

    // Load has priority; otherwise count down while nonzero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero_c = (value == '0);

endmodule

// File: rtl/door_controller.sv
// Motorised door sequencer: open/hold/close with limit sensors, obstacle
// reversal, motion timeout and per-channel request masking.
// Optional macro: DOOR_OPEN_CNT_EN enables open_count_o.
module door_controller
    import door_controller_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned HOLD    = 50,
    parameter int unsigned MOVE_TO = 200
`ifdef DOOR_OPEN_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input logic               clk,
    input logic               rst_n,
    door_controller_if.slave  bus
);

    localparam int unsigned TMR_W = $clog2(max_u(HOLD, MOVE_TO) + 1);

    door_state_e        state;
    door_state_e        next_state;
    logic               open_req;
    logic               sensor_conflict;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_load_val;
    logic [TMR_W-1:0]   tmr_value;
    logic               tmr_zero_c;
    logic               tmr_last;

    door_controller_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_value),
        .zero_c   (tmr_zero_c)
    );

    // Masked, lock-qualified request and the impossible both-limits condition.
    assign open_req        = ~bus.lock_i & (|(bus.req_i & bus.req_mask_i));
    assign sensor_conflict = bus.open_lim_i & bus.closed_lim_i;
    // Timer expires on the edge where it would step down to zero.
    assign tmr_last        = tmr_zero_c | (tmr_value == TMR_W'(1));

    // Next-state and timer-reload decision.
    always_comb begin
        next_state   = state;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        unique case (state)
            ST_CLOSED: begin
                if (open_req) begin
                    next_state   = ST_OPENING;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(MOVE_TO);
                end else if (!bus.closed_lim_i) begin
                    next_state   = ST_CLOSING;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(MOVE_TO);
                end
            end
            ST_OPENING: begin
                if (sensor_conflict) begin
                    next_state = ST_FAULT;
                end else if (bus.open_lim_i) begin
                    next_state   = ST_OPEN;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(HOLD);
                end else if (tmr_last) begin
                    next_state = ST_FAULT;
                end
            end
            ST_OPEN: begin
                if (open_req || bus.obstacle_i) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(HOLD);
                end else if (tmr_last) begin
                    next_state   = ST_CLOSING;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(MOVE_TO);
                end
            end
            ST_CLOSING: begin
                if (sensor_conflict) begin
                    next_state = ST_FAULT;
                end else if (bus.obstacle_i || open_req) begin
                    next_state   = ST_OPENING;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(MOVE_TO);
                end else if (bus.closed_lim_i) begin
                    next_state = ST_CLOSED;
                end else if (tmr_last) begin
                    next_state = ST_FAULT;
                end
            end
            ST_FAULT: begin
                next_state = ST_FAULT;
            end
            default: begin
                next_state = ST_FAULT;
            end
        endcase
    end

    // State register with outputs decoded from the incoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_CLOSED;
            bus.motor_open_o  <= 1'b0;
            bus.motor_close_o <= 1'b0;
            bus.door_open_o   <= 1'b0;
            bus.fault_o       <= 1'b0;
            bus.state_o       <= ST_CLOSED;
        end else begin
            state             <= next_state;
            bus.motor_open_o  <= (next_state == ST_OPENING);
            bus.motor_close_o <= (next_state == ST_CLOSING);
            bus.door_open_o   <= (next_state == ST_OPEN);
            bus.fault_o       <= (next_state == ST_FAULT);
            bus.state_o       <= next_state;
        end
    end

`ifdef DOOR_OPEN_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] open_cnt;

    // Saturating count of completed openings.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            open_cnt <= '0;
        end else if ((state == ST_OPENING) && (next_state == ST_OPEN) && (open_cnt != CNT_MAX)) begin
            open_cnt <= open_cnt + CNT_W'(1);
        end
    end

    assign bus.open_count_o = open_cnt;
`endif

endmodule
